// File: rtl/spi_sys_pkg.sv
// rtl/spi_sys_pkg.sv - shared types and constants for the sys bus router
package spi_sys_pkg;

  localparam int PAGE_W = 7;
  localparam int OFS_W  = 8;
  localparam int ADDR_W = PAGE_W + OFS_W;

  localparam logic [15:0] DEF_ERR_DATA = 16'hDEAD;
  localparam int          DEF_TIMEOUT  = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RD = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sys_rd_timer.sv
// rtl/spi_sys_rd_timer.sv - read acknowledge timer with expiry flag
module spi_sys_rd_timer
  import spi_sys_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_q, count_d;

  // Clear wins over enable; the count holds at full scale rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 8'(TIMEOUT));

endmodule

// File: rtl/spi_sys_router.sv
// rtl/spi_sys_router.sv - routes the SPI slave sys bus to paged register targets
module spi_sys_router
  import spi_sys_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter logic [PAGE_W-1:0] BASE_PAGE = 7'h01,
  parameter int                DW        = 16,
  parameter int                TIMEOUT   = DEF_TIMEOUT,
  parameter logic [DW-1:0]     ERR_DATA  = DW'(DEF_ERR_DATA)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 up_wr_en,
  input  logic                 up_rd_en,
  input  logic [ADDR_W-1:0]    up_addr,
  input  logic [DW-1:0]        up_wdata,
  output logic [DW-1:0]        up_rdata,
  output logic                 up_rvalid,
  output logic                 up_err,
  output logic                 busy,
  output logic [NUM_CH-1:0]    dn_wr_en,
  output logic [NUM_CH-1:0]    dn_rd_en,
  output logic [OFS_W-1:0]     dn_addr,
  output logic [DW-1:0]        dn_wdata,
  input  logic [NUM_CH*DW-1:0] dn_rdata,
  input  logic [NUM_CH-1:0]    dn_rack,
  output logic [7:0]           err_count
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [OFS_W-1:0]    addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [7:0]          page8, lo8, hi8;
  logic                hit;
  logic [CH_W-1:0]     req_ch;
  logic [NUM_CH-1:0]   req_onehot;
  logic                tmr_clear, tmr_expired;

  // 8-bit page arithmetic so BASE_PAGE+NUM_CH cannot wrap past page 7'h7F.
  assign page8  = {1'b0, up_addr[ADDR_W-1:OFS_W]};
  assign lo8    = {1'b0, BASE_PAGE};
  assign hi8    = lo8 + 8'(NUM_CH);
  assign hit    = (page8 >= lo8) && (page8 < hi8);
  assign req_ch = CH_W'(page8 - lo8);

  // One-hot strobe pattern for the decoded channel.
  always_comb begin
    req_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_onehot[i] = (req_ch == CH_W'(i));
    end
  end

  // Next-state and response logic; any error pulse also bumps the counter once.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    wr_d      = '0;
    rd_d      = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    tmr_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (up_wr_en) begin
          if (hit) begin
            wr_d    = req_onehot;
            addr_d  = up_addr[OFS_W-1:0];
            wdata_d = up_wdata;
          end else begin
            err_d = 1'b1;
          end
          // A coincident read loses to the write and is reported as dropped.
          if (up_rd_en) err_d = 1'b1;
        end else if (up_rd_en) begin
          if (hit) begin
            rd_d      = req_onehot;
            addr_d    = up_addr[OFS_W-1:0];
            ch_d      = req_ch;
            tmr_clear = 1'b1;
            state_d   = ST_WAIT_RD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT_RD: begin
        // The ack is checked first so it wins over a coincident expiry.
        if (dn_rack[ch_q]) begin
          rdata_d  = dn_rdata[int'(ch_q)*DW +: DW];
          rvalid_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (tmr_expired) begin
          rdata_d  = ERR_DATA;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end
        if (up_wr_en || up_rd_en) err_d = 1'b1;
      end
      ST_RESP: begin
        // Unmapped read answer; requests arriving now fold into the same error.
        rdata_d  = ERR_DATA;
        rvalid_d = 1'b1;
        err_d    = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  spi_sys_rd_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_rd_timer (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clear   (tmr_clear),
    .enable  (state_q == ST_WAIT_RD),
    .expired (tmr_expired)
  );

  assign up_rdata  = rdata_q;
  assign up_rvalid = rvalid_q;
  assign up_err    = err_q;
  assign busy      = (state_q == ST_WAIT_RD);
  assign dn_wr_en  = wr_q;
  assign dn_rd_en  = rd_q;
  assign dn_addr   = addr_q;
  assign dn_wdata  = wdata_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/spi_sys_router.md
Name: spi_sys_router

Overview:
- Parametrised successor to the single-master/single-register-page address decoder between the SPI slave's system bus and its register targets.
- Routes one upstream sys bus (write/read strobes, 15-bit address, 16-bit data) to NUM_CH downstream targets, one per contiguous page: address[14:8] = BASE_PAGE + i.
- Adds what the fixed decoder lacks: an acknowledged read handshake with timeout, error reporting for unmapped, busy and timed-out accesses, and a saturating error counter.

Parameters:
- NUM_CH, 4, number of downstream targets (1..16).
- BASE_PAGE, 7'h01, page of channel 0; channel i sits at page BASE_PAGE+i.
- DW, 16, data width.
- TIMEOUT, 15, cycles to wait for dn_rack before aborting a read (1..255).
- ERR_DATA, 16'hDEAD, read data returned on any error.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- up_wr_en  in  1  write strobe, single-cycle pulse
- up_rd_en  in  1  read strobe, single-cycle pulse
- up_addr  in  15  [14:8] page, [7:0] register offset
- up_wdata  in  DW  write data
- up_rdata  out  DW  read data; holds until next response
- up_rvalid  out  1  one-cycle pulse when up_rdata is updated
- up_err  out  1  one-cycle pulse marking an error response or a dropped request
- busy  out  1  high while a read is outstanding
- dn_wr_en  out  NUM_CH  one-hot write strobe
- dn_rd_en  out  NUM_CH  one-hot read strobe
- dn_addr  out  8  shared register offset
- dn_wdata  out  DW  shared write data
- dn_rdata  in  NUM_CH*DW  channel i read data in slice [i*DW +: DW]
- dn_rack  in  NUM_CH  channel i read acknowledge; dn_rdata slice valid that cycle
- err_count  out  8  saturating count of errors

Behaviour:
- Reset: state IDLE; all outputs 0, including up_rdata, dn_addr, dn_wdata and err_count. Reset mid-read aborts the read silently with no rvalid.
- Decode: hit when BASE_PAGE <= up_addr[14:8] < BASE_PAGE+NUM_CH; ch = page - BASE_PAGE. Use 8-bit arithmetic so BASE_PAGE+NUM_CH cannot wrap.
- FSM states: IDLE, WAIT_RD, RESP.
- IDLE, write, hit (up_wr_en at cycle n):
  - At n+1: dn_wr_en[ch]=1 for exactly one cycle, with dn_addr/dn_wdata registered.
  - No rvalid.
- IDLE, write, miss: no strobe; up_err pulses at n+1; err_count++.
- IDLE, read, hit:
  - At n+1: dn_rd_en[ch] pulses and dn_addr is set; busy=1; state WAIT_RD; timer cleared.
- IDLE, read, miss:
  - At n+1: state RESP with ERR_DATA captured.
  - At n+2: up_rvalid=1, up_err=1, up_rdata=ERR_DATA; err_count++.
- WAIT_RD:
  - Timer increments each cycle.
  - dn_rack[ch] in cycle m: capture the ch slice; at m+1 up_rvalid=1, up_rdata=slice, busy=0; state IDLE.
  - dn_rack on any other channel is ignored.
  - If the timer reaches TIMEOUT with no ack: at the next cycle up_rvalid=1, up_err=1, up_rdata=ERR_DATA, busy=0, err_count++; state IDLE.
  - Ack in the same cycle as the timer hits TIMEOUT: the ack wins.
- Any up_wr_en/up_rd_en while busy or in RESP: request dropped, up_err pulses next cycle, err_count++. No downstream strobe, no rvalid.
- up_wr_en and up_rd_en in the same cycle: write is processed, read is dropped as an error.
- err_count: saturates at 8'hFF and never wraps. Increments by at most 1 per cycle; a coincident drop and response error count once.
- up_rdata changes only on an up_rvalid cycle.

Decomposition:
- Package spi_sys_pkg holds:
  - FSM state encoding (IDLE/WAIT_RD/RESP)
  - PAGE_W=7 and OFS_W=8 constants
  - default ERR_DATA and TIMEOUT
- One sub-module, spi_sys_rd_timer: clear, enable, an 8-bit counter and an expired flag at TIMEOUT.

Test Plan:
- Write 0x0203=0x1234 with NUM_CH=4 -> next cycle dn_wr_en=4'b0010, dn_addr=8'h03, dn_wdata=16'h1234, for one cycle only.
- Read 0x0340; ch2 returns dn_rack 3 cycles after dn_rd_en with data 0xBEEF -> up_rvalid one cycle later, up_rdata=0xBEEF, up_err=0, busy low after the response.
- Read 0x0100 with no dn_rack, TIMEOUT=15 -> up_rvalid+up_err with up_rdata=0xDEAD 16 cycles after dn_rd_en; err_count=1.
- Read 0x0700 (unmapped) -> no dn_rd_en; rvalid+err at n+2 with 0xDEAD. Write 0x0000 -> no strobe, err pulse; err_count=2.
- Issue a write during WAIT_RD -> dropped, up_err pulses, no dn_wr_en. Simultaneous wr+rd in IDLE -> only dn_wr_en, one err pulse.
- Assert sys_rst_n low in WAIT_RD -> all outputs 0 immediately, no rvalid after release. Force 300 errors -> err_count holds at 8'hFF.
